// File: rtl/dcp_tx_fmt_if.sv
// Bundle between the print engines / UART transmitter and dcp_tx_fmt.
// The master side drives the request and tx_ready; the slave side is the formatter.
interface dcp_tx_fmt_if #(
  parameter int DATA_W = 32
);
  logic              req_tx;
  logic              type_tx;
  logic [DATA_W-1:0] din;
  logic              ack_tx;
  logic              busy;
  logic [7:0]        tx_byte;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output req_tx, type_tx, din, tx_ready,
    input  ack_tx, busy, tx_byte, tx_valid
  );

  modport slave (
    input  req_tx, type_tx, din, tx_ready,
    output ack_tx, busy, tx_byte, tx_valid
  );
endinterface

// File: rtl/dcp_tx_fmt.sv
// Serial TX formatter: one raw byte or a DATA_W-bit word as hex ASCII per req/ack handshake,
// pushed into the UART byte stream over valid/ready.
module dcp_tx_fmt #(
  parameter int DATA_W    = 32,
  parameter bit HEX_UPPER = 1'b1
) (
  input logic         clk,
  input logic         rst,
  dcp_tx_fmt_if.slave bus
);
  localparam int HEX_N = DATA_W / 4;
  localparam int CNT_W = (HEX_N > 1) ? $clog2(HEX_N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_ACK,
    S_WAIT_LOW
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_type;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_accept;
  logic              w_xfer;
  logic [DATA_W-1:0] w_shift;
  logic [3:0]        w_nib;
  logic [7:0]        w_hex;

  assign w_accept = (r_state == S_IDLE) && bus.req_tx;
  assign w_xfer   = (r_state == S_SEND) && bus.tx_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (bus.req_tx) w_next = S_SEND;
      S_SEND:     if (w_xfer && (r_cnt == '0)) w_next = S_ACK;
      S_ACK:      w_next = S_WAIT_LOW;
      S_WAIT_LOW: if (!bus.req_tx) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Counter walks from the MS nibble down; it stops at zero and the FSM leaves SEND there.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_type <= 1'b0;
      r_data <= '0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_type <= bus.type_tx;
      r_data <= bus.din;
      r_cnt  <= bus.type_tx ? CNT_W'(HEX_N - 1) : '0;
    end else if (w_xfer && (r_cnt != '0)) begin
      r_cnt  <= r_cnt - CNT_W'(1);
    end
  end

  assign w_shift = r_data >> {r_cnt, 2'b00};
  assign w_nib   = w_shift[3:0];
  assign w_hex   = (w_nib < 4'd10) ? (8'h30 + {4'h0, w_nib})
                                   : ((HEX_UPPER ? 8'h41 : 8'h61) + {4'h0, w_nib} - 8'd10);

  assign bus.tx_valid = (r_state == S_SEND);
  assign bus.tx_byte  = (r_state == S_SEND) ? (r_type ? w_hex : r_data[7:0]) : 8'h00;
  assign bus.ack_tx   = (r_state == S_ACK);
  assign bus.busy     = (r_state != S_IDLE);
endmodule

// File: tb/tb_dcp_tx_fmt.sv
// Directed bench for dcp_tx_fmt: an upper-case and a lower-case instance run in lockstep.
module tb_dcp_tx_fmt;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  dcp_tx_fmt_if #(.DATA_W(32)) if_u ();
  dcp_tx_fmt_if #(.DATA_W(32)) if_l ();

  assign if_l.req_tx   = if_u.req_tx;
  assign if_l.type_tx  = if_u.type_tx;
  assign if_l.din      = if_u.din;
  assign if_l.tx_ready = if_u.tx_ready;

  dcp_tx_fmt #(.DATA_W(32), .HEX_UPPER(1'b1)) u_dut_up (.clk(clk), .rst(rst), .bus(if_u));
  dcp_tx_fmt #(.DATA_W(32), .HEX_UPPER(1'b0)) u_dut_lo (.clk(clk), .rst(rst), .bus(if_l));

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one request and follows it to its ack; returns at the negedge where ack_tx is seen.
  // Expected bytes are packed MS byte first in eu (upper DUT) / el (lower DUT).
  task automatic xfer(input string tag, input logic t, input logic [31:0] d, input int stall,
                      input int n, input logic [63:0] eu, input logic [63:0] el, input bit chg);
    int   idx  = 0;
    int   sc   = 0;
    int   cyc  = 0;
    int   last = -10;
    bit   got  = 0;
    logic [7:0] bu, bl;
    if_u.type_tx  = t;
    if_u.din      = d;
    if_u.req_tx   = 1'b1;
    if_u.tx_ready = (stall == 0);
    while (!got && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (chg && cyc == 1) begin
        if_u.din     = 32'hFFFF_FFFF;
        if_u.type_tx = ~t;
      end
      if (if_u.ack_tx) begin
        got = 1;
        chk({tag, " transfers"}, idx, n);
        chk({tag, " ack latency"}, cyc - last, 1);
        chk({tag, " valid at ack"}, if_u.tx_valid, 1'b0);
        chk({tag, " lo ack"}, if_l.ack_tx, 1'b1);
      end else if (if_u.tx_valid) begin
        bu = (idx < n) ? 8'(eu >> (56 - 8 * idx)) : 8'hxx;
        bl = (idx < n) ? 8'(el >> (56 - 8 * idx)) : 8'hxx;
        chk({tag, " byte up"}, if_u.tx_byte, bu);
        chk({tag, " byte lo"}, if_l.tx_byte, bl);
        chk({tag, " busy"}, if_u.busy, 1'b1);
        if (sc < stall) begin
          if_u.tx_ready = 1'b0;
          sc++;
        end else begin
          if_u.tx_ready = 1'b1;
          idx++;
          sc   = 0;
          last = cyc;
        end
      end else begin
        chk({tag, " valid gap"}, {31'd0, (idx == 0 && cyc == 1) ? 1'b0 : 1'b1}, 32'd0);
      end
    end
    chk({tag, " ack seen"}, got, 1'b1);
  endtask

  initial begin
    rst           = 1'b1;
    if_u.req_tx   = 1'b0;
    if_u.type_tx  = 1'b0;
    if_u.din      = '0;
    if_u.tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset valid", if_u.tx_valid, 1'b0);
    chk("reset byte", if_u.tx_byte, 8'h00);
    chk("reset busy", if_u.busy, 1'b0);
    chk("reset ack", if_u.ack_tx, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // raw byte, then busy drops two cycles after the ack pulse
    xfer("raw52", 1'b0, 32'h52, 0, 1, 64'h5200_0000_0000_0000, 64'h5200_0000_0000_0000, 1'b0);
    if_u.req_tx = 1'b0;
    @(negedge clk);
    chk("raw52 ack pulse", if_u.ack_tx, 1'b0);
    chk("raw52 busy wait", if_u.busy, 1'b1);
    @(negedge clk);
    chk("raw52 busy low", if_u.busy, 1'b0);

    // hex word back-to-back, then req held high after ack must not retrigger
    xfer("hex1234", 1'b1, 32'h1234_ABCD, 0, 8,
         64'h3132_3334_4142_4344, 64'h3132_3334_6162_6364, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold valid", if_u.tx_valid, 1'b0);
      chk("hold ack", if_u.ack_tx, 1'b0);
      chk("hold busy", if_u.busy, 1'b1);
    end
    if_u.req_tx = 1'b0;
    @(negedge clk);
    xfer("raw0D", 1'b0, 32'h0D, 0, 1, 64'h0D00_0000_0000_0000, 64'h0D00_0000_0000_0000, 1'b0);
    if_u.req_tx = 1'b0;
    repeat (2) @(negedge clk);

    // stalled hex transfer: every stalled cycle re-checks the held byte
    xfer("hex0F", 1'b1, 32'h0000_000F, 5, 8,
         64'h3030_3030_3030_3046, 64'h3030_3030_3030_3066, 1'b0);
    if_u.req_tx = 1'b0;
    repeat (2) @(negedge clk);

    // reset mid-transfer aborts without ack
    if_u.type_tx  = 1'b1;
    if_u.din      = 32'hDEAD_BEEF;
    if_u.req_tx   = 1'b1;
    if_u.tx_ready = 1'b1;
    @(negedge clk);
    chk("abort b0", if_u.tx_byte, 8'h44);
    @(negedge clk);
    chk("abort b1", if_u.tx_byte, 8'h45);
    @(negedge clk);
    chk("abort b2", if_u.tx_byte, 8'h41);
    @(negedge clk);
    chk("abort b3", if_u.tx_byte, 8'h44);
    rst         = 1'b1;
    if_u.req_tx = 1'b0;
    @(negedge clk);
    chk("abort valid", if_u.tx_valid, 1'b0);
    chk("abort busy", if_u.busy, 1'b0);
    chk("abort ack", if_u.ack_tx, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post abort ack", if_u.ack_tx, 1'b0);
      chk("post abort valid", if_u.tx_valid, 1'b0);
    end
    xfer("hexDEAD", 1'b1, 32'hDEAD_BEEF, 0, 8,
         64'h4445_4144_4245_4546, 64'h6465_6164_6265_6566, 1'b0);
    if_u.req_tx = 1'b0;
    repeat (2) @(negedge clk);

    // din and type_tx changed right after acceptance are ignored
    xfer("hexchg", 1'b1, 32'h0123_4567, 0, 8,
         64'h3031_3233_3435_3637, 64'h3031_3233_3435_3637, 1'b1);
    if_u.req_tx = 1'b0;
    repeat (2) @(negedge clk);
    chk("final busy", if_u.busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
